// File: rtl/xt_bus_dma_target.sv
// XT-bus I/O and DMA target: a device-to-host byte FIFO drained by CPU port reads or
// DMA cycles, with programmable wait states and a terminal-count interrupt.
`timescale 1ns/1ps

module xt_bus_dma_target #(
    parameter logic [9:0] IO_BASE     = 10'h300,
    parameter int         FIFO_DEPTH  = 16,
    parameter int         WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic        address_enable_n,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic [7:0]  data_bus_in,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_enable,
    output logic        io_channel_ready,
    output logic        dma_request,
    input  logic        dma_acknowledge_n,
    input  logic        terminal_count_n,
    output logic        interrupt_request,
    input  logic        dev_valid,
    input  logic [7:0]  dev_data,
    output logic        dev_ready
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [2:0] WAIT_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE,
        ST_END
    } state_t;

    state_t        state, state_next;
    logic          enter_active;
    logic [2:0]    wait_cnt;

    // Access context: captured when the cycle starts, data latched on ACTIVE entry.
    logic          acc_read, acc_dma, acc_empty, acc_tc;
    logic [1:0]    acc_port;
    logic [7:0]    acc_wdata, acc_rdata;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, push, pop;

    logic          dma_en, irq_en, tc_seen, underrun;

    logic          cpu_sel, dma_sel, start;
    logic          cur_dma;
    logic [1:0]    cur_port;
    logic [7:0]    rd_value, status_byte;
    logic          in_end, fifo_rd_end, underrun_set, status_rd, ctrl_wr, flush, clr_tc, tc_end;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^address[19:10];

    assign cpu_sel = ~address_enable_n & (address[9:2] == IO_BASE[9:2]);
    assign dma_sel = ~dma_acknowledge_n & address_enable_n;
    assign start   = (~io_read_n | ~io_write_n) & (cpu_sel | dma_sel);

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and no latch is inferred.
        state_next          = state;
        enter_active        = 1'b0;
        io_channel_ready    = 1'b1;
        data_bus_out_enable = 1'b0;
        data_bus_out        = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (WAIT_STATES == 0) begin
                        state_next   = ST_ACTIVE;
                        enter_active = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                io_channel_ready = 1'b0;
                if (wait_cnt == 3'd0) begin
                    state_next   = ST_ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ST_ACTIVE: begin
                data_bus_out_enable = acc_read;
                data_bus_out        = acc_read ? acc_rdata : 8'h00;
                if (acc_read ? io_read_n : io_write_n) state_next = ST_END;
            end
            ST_END:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // With zero wait states ACTIVE is entered straight from IDLE, before the context is captured.
    assign cur_dma  = (state == ST_IDLE) ? dma_sel : acc_dma;
    assign cur_port = (state == ST_IDLE) ? address[1:0] : acc_port;

    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign status_byte = {underrun, tc_seen, irq_en, dma_en, full, empty, count[1:0]};

    always_comb begin
        rd_value = 8'hFF;
        if (cur_dma || cur_port == 2'd0) begin
            rd_value = empty ? 8'hFF : mem[rd_ptr];
        end else begin
            case (cur_port)
                2'd1:    rd_value = status_byte;
                2'd2:    rd_value = {6'b0, irq_en, dma_en};
                default: rd_value = 8'(count);
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_read  <= 1'b0;
            acc_dma   <= 1'b0;
            acc_port  <= 2'd0;
            acc_empty <= 1'b0;
            acc_tc    <= 1'b0;
            acc_wdata <= 8'h00;
            acc_rdata <= 8'h00;
            wait_cnt  <= 3'd0;
        end else begin
            if (state == ST_IDLE && start) begin
                acc_read <= ~io_read_n;
                acc_dma  <= dma_sel;
                acc_port <= address[1:0];
                wait_cnt <= WAIT_LAST;
            end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (enter_active) begin
                acc_rdata <= rd_value;
                acc_empty <= empty;
                acc_wdata <= data_bus_in;
            end
            if (state == ST_IDLE)
                acc_tc <= 1'b0;
            else if (state == ST_ACTIVE && acc_dma && !terminal_count_n)
                acc_tc <= 1'b1;
        end
    end

    // Every architectural side effect is confined to the END clock.
    assign in_end       = (state == ST_END);
    assign fifo_rd_end  = in_end & acc_read & (acc_dma | (acc_port == 2'd0));
    assign pop          = fifo_rd_end & ~acc_empty;
    assign underrun_set = fifo_rd_end & acc_empty;
    assign status_rd    = in_end & acc_read & ~acc_dma & (acc_port == 2'd1);
    assign ctrl_wr      = in_end & ~acc_read & ~acc_dma & (acc_port == 2'd2);
    assign flush        = ctrl_wr & acc_wdata[2];
    assign clr_tc       = ctrl_wr & acc_wdata[3];
    assign tc_end       = in_end & acc_read & acc_dma & acc_tc;

    assign dev_ready = ~full & ~flush;
    assign push      = dev_valid & dev_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= dev_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dma_en      <= 1'b0;
            irq_en      <= 1'b0;
            tc_seen     <= 1'b0;
            underrun    <= 1'b0;
            dma_request <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                dma_en <= acc_wdata[0];
                irq_en <= acc_wdata[1];
            end else if (tc_end) begin
                dma_en <= 1'b0;
            end
            if (tc_end)      tc_seen <= 1'b1;
            else if (clr_tc) tc_seen <= 1'b0;
            if (underrun_set)   underrun <= 1'b1;
            else if (status_rd) underrun <= 1'b0;
            // Registered so DRQ falls on the edge that samples DACK low and rises again only once back in IDLE.
            dma_request <= dma_en & ~empty & (state == ST_IDLE) & dma_acknowledge_n;
        end
    end

    assign interrupt_request = tc_seen & irq_en;

endmodule

// File: doc/xt_bus_dma_target.md
XT_BUS_DMA_TARGET -- requirements
Module: xt_bus_dma_target

Interface
REQ-001 Parameter IO_BASE, 10'h300, I/O base address; decodes 4 ports, IO_BASE+0..+3.
REQ-002 Parameter FIFO_DEPTH, 16, device-to-host byte FIFO depth (power of two, 4..64).
REQ-003 Parameter WAIT_STATES, 1, clocks io_channel_ready is held low per decoded access (0..7).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  in  1  sole clock; all bus inputs are synchronous to it.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 address  in  20  bus address; only bits [9:0] are decoded.
REQ-008 address_enable_n  in  1  low = CPU cycle; high = DMA cycle (address decode is ignored).
REQ-009 io_read_n / io_write_n  in  1 each  bus I/O strobes, active low.
REQ-010 data_bus_in  in  8  bus write data.
REQ-011 data_bus_out  out  8  read data; data_bus_out_enable  out  1  high while the block drives the bus.
REQ-012 io_channel_ready  out  1  low inserts wait states.
REQ-013 dma_request  out  1  DRQ; dma_acknowledge_n  in  1  DACK; terminal_count_n  in  1  TC, active low.
REQ-014 interrupt_request  out  1  level IRQ.
REQ-015 dev_valid  in  1; dev_data  in  8; dev_ready  out  1: device push stream; transfer when valid & ready.

Function
REQ-016 Select: CPU_SEL = ~address_enable_n & address[9:2]==IO_BASE[9:2]; DMA_SEL = ~dma_acknowledge_n & address_enable_n.
REQ-017 Registers: +0 R data (pop); +1 R status {underrun, tc_seen, irq_en, dma_en, full, empty, count[1:0]}; +2 W control {bit0 dma_en, bit1 irq_en, bit2 flush, bit3 clr_tc}; +3 R count (zero-extended).
REQ-018 Access FSM states: IDLE, WAIT, ACTIVE, END.
REQ-019 IDLE->WAIT on the first clock with a strobe low and CPU_SEL or DMA_SEL (WAIT_STATES=0: IDLE->ACTIVE directly).
REQ-020 In WAIT, io_channel_ready = 0 for exactly WAIT_STATES clocks, then ACTIVE; io_channel_ready = 1 in all other states.
REQ-021 In ACTIVE on a read, data_bus_out_enable = 1 and data_bus_out holds the selected value; the value is latched on ACTIVE entry.
REQ-022 ACTIVE->END when the strobe returns high; END->IDLE after one clock.
REQ-023 Side effects apply only in END: pop for a data-port or DMA read; register write latched from data_bus_in captured on ACTIVE entry.
REQ-024 Read of an empty FIFO returns 8'hFF, does not pop, and sets underrun; underrun clears on read of the status port.
REQ-025 dma_request = 1 when dma_en & ~empty & FSM in IDLE & dma_acknowledge_n high.
REQ-026 dma_request drops on the clock DACK is sampled low; it stays low until END completes.
REQ-027 TC sampled low during a DMA ACTIVE cycle: in END, set tc_seen and clear dma_en.
REQ-028 interrupt_request = tc_seen & irq_en (level); clr_tc clears tc_seen.
REQ-029 dev_ready = ~full & ~flush_pending; push and pop in the same clock leave count unchanged.
REQ-030 Flush empties the FIFO in END of the control write; a push in that clock is dropped (dev_ready = 0 that clock).
REQ-031 Pointers wrap modulo FIFO_DEPTH; count width = log2(FIFO_DEPTH)+1.
REQ-032 A DMA_SEL cycle with io_write_n low completes the FSM with wait states but has no side effect.

Reset
REQ-033 On reset_n low, immediately: data_bus_out = 8'h00, data_bus_out_enable = 0, io_channel_ready = 1, dma_request = 0, interrupt_request = 0.
REQ-034 On reset_n low, immediately: dev_ready = 1, FIFO empty, control = 0, tc_seen = 0, underrun = 0, FSM = IDLE.
REQ-035 Reset asserted mid-access aborts the access with no pop and no register write.

Verification
REQ-036 Push 3 bytes (0x11, 0x22, 0x33); CPU I/O read of 0x300 -> ready low 1 clock, bus drives 0x11; count 3->2 only after io_read_n rises.
REQ-037 Write 0x01 to 0x302 with 2 bytes queued -> DRQ=1; DACK with io_read_n -> DRQ drops next clock, bytes 0x11 then 0x22 driven; DRQ stays 0 when empty.
REQ-038 DMA read with terminal_count_n low, irq_en=1 -> tc_seen=1, dma_en=0, IRQ=1; write 0x08 to 0x302 -> IRQ=0.
REQ-039 Read 0x300 while empty -> 0xFF, count stays 0, status bit7=1; second status read -> bit7=0.
REQ-040 Fill to FIFO_DEPTH -> dev_ready=0; simultaneous push+pop at count 8 -> count stays 8; flush coincident with push -> count 0.
REQ-041 Assert reset_n low during WAIT of a data-port read -> io_channel_ready=1, bus released, count unchanged.
